// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and
// the default location of the data window in the byte address space.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with one synchronous bit-masked write port and an
// asynchronous read port. Contents are deliberately not reset.
module dmem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] wmask,
  input  logic [IDX_W-1:0] ridx,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Masked merge: bits with a 0 mask keep their previous value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= (mem[widx] & ~wmask) | (wdata & wmask);
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Target-side responder for the MEM stage data-memory interface: one request
// at a time, writes commit on the accept edge, response after LATENCY cycles.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 1024,
  parameter logic [WIDTH-1:0] BASE_ADDR = WIDTH'(DEFAULT_BASE_ADDR),
  parameter int               LATENCY   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [WIDTH-1:0] req_mask,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err
);

  localparam int               BYTE_SHIFT = $clog2(WIDTH / 8);
  localparam int               IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W      = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [WIDTH-1:0] DEPTH_W    = WIDTH'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD   = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               we_q, we_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic               in_range_q, in_range_n;
  logic [WIDTH-1:0]   rdata_n;
  logic               err_n;

  logic [WIDTH-1:0]   addr_off;
  logic [WIDTH-1:0]   addr_word;
  logic               dec_in_range;
  logic [IDX_W-1:0]   dec_idx;
  logic               accept;
  logic               arr_we;
  logic [IDX_W-1:0]   arr_ridx;
  logic [WIDTH-1:0]   arr_rdata;

  // The >= guard rejects addresses below the window before the subtraction
  // can wrap around into a small, seemingly valid offset.
  assign addr_off     = req_addr - BASE_ADDR;
  assign addr_word    = addr_off >> BYTE_SHIFT;
  assign dec_in_range = (req_addr >= BASE_ADDR) && (addr_word < DEPTH_W);
  assign dec_idx      = addr_word[IDX_W-1:0];

  assign req_ready  = (state == IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);
  assign arr_we     = accept && req_we && dec_in_range;
  // A LATENCY of 1 loads the response on the accept edge, so the read port
  // must look at the live request rather than the latched index.
  assign arr_ridx   = (state == IDLE) ? dec_idx : idx_q;

  dmem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .widx  (dec_idx),
    .wdata (req_wdata),
    .wmask (req_mask),
    .ridx  (arr_ridx),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    we_n       = we_q;
    idx_n      = idx_q;
    in_range_n = in_range_q;
    rdata_n    = resp_rdata;
    err_n      = resp_err;
    case (state)
      IDLE: begin
        if (accept) begin
          we_n       = req_we;
          idx_n      = dec_idx;
          in_range_n = dec_in_range;
          if (LATENCY == 1) begin
            state_n = RESP;
            rdata_n = (!req_we && dec_in_range) ? arr_rdata : '0;
            err_n   = !dec_in_range;
          end else begin
            state_n = BUSY;
            cnt_n   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_n = RESP;
          rdata_n = (!we_q && in_range_q) ? arr_rdata : '0;
          err_n   = !in_range_q;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_n = IDLE;
          rdata_n = '0;
          err_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      we_q       <= we_n;
      idx_q      <= idx_n;
      in_range_q <= in_range_n;
      resp_rdata <= rdata_n;
      resp_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: a transaction-level model predicts every output each
// cycle, plus directed literal checks and a LATENCY=1 throughput instance.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_mask = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        l1_req_valid = 1'b0;
  logic        l1_req_ready;
  logic        l1_req_we = 1'b0;
  logic [31:0] l1_req_addr = '0;
  logic [31:0] l1_req_wdata = '0;
  logic [31:0] l1_req_mask = '0;
  logic        l1_resp_valid;
  logic        l1_resp_ready = 1'b1;
  logic [31:0] l1_resp_rdata;
  logic        l1_resp_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .WIDTH (32), .DEPTH (DEPTH), .BASE_ADDR (BASE), .LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_mask   (req_mask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  dmem_responder #(
    .WIDTH (32), .DEPTH (16), .BASE_ADDR (BASE), .LATENCY (1)
  ) dut_l1 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (l1_req_valid),
    .req_ready  (l1_req_ready),
    .req_we     (l1_req_we),
    .req_addr   (l1_req_addr),
    .req_wdata  (l1_req_wdata),
    .req_mask   (l1_req_mask),
    .resp_valid (l1_resp_valid),
    .resp_ready (l1_resp_ready),
    .resp_rdata (l1_resp_rdata),
    .resp_err   (l1_resp_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  // Transaction-level reference: one outstanding request, due LAT cycles later.
  logic [31:0] model_mem [int];
  int          cyc = 0;
  bit          m_out = 1'b0;
  int          m_due = 0;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;

  always @(negedge clk) begin
    logic        e_ready, e_valid, e_err, in_r;
    logic [31:0] e_rdata, old;
    longint      off;
    int          idx;
    cyc++;
    if (rst) m_out = 1'b0;
    e_ready = !rst && !m_out;
    e_valid = m_out && (cyc >= m_due);
    e_rdata = e_valid ? m_rdata : 32'h0;
    e_err   = e_valid ? m_err : 1'b0;
    checkOutput("req_ready", {31'b0, req_ready}, {31'b0, e_ready});
    checkOutput("resp_valid", {31'b0, resp_valid}, {31'b0, e_valid});
    checkOutput("resp_rdata", resp_rdata, e_rdata);
    checkOutput("resp_err", {31'b0, resp_err}, {31'b0, e_err});
    if (!rst) begin
      if (e_valid && resp_ready) begin
        m_out = 1'b0;
      end else if (e_ready && req_valid) begin
        off  = longint'(req_addr) - longint'(BASE);
        in_r = (off >= 0) && ((off / 4) < DEPTH);
        idx  = in_r ? int'(off / 4) : 0;
        if (req_we) begin
          if (in_r) begin
            old = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
            model_mem[idx] = (old & ~req_mask) | (req_wdata & req_mask);
          end
          m_rdata = 32'h0;
        end else begin
          m_rdata = (in_r && model_mem.exists(idx)) ? model_mem[idx] : 32'h0;
        end
        m_err = !in_r;
        m_out = 1'b1;
        m_due = cyc + LAT;
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] mask,
                               input int hold, input bit noise,
                               output logic [31:0] rdata, output logic err,
                               output int lat);
    int guard;
    rdata = '0;
    err   = 1'b0;
    lat   = -1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr;
    req_wdata = wdata; req_mask = mask;
    resp_ready = (hold == 0);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!req_ready && guard < 20);
    if (!req_ready) begin
      reportTimeout("accept");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    req_we = 1'($urandom_range(0, 1));
    req_addr = $urandom; req_wdata = $urandom; req_mask = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    if (!resp_valid) begin
      reportTimeout("response");
      req_valid = 1'b0;
      resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      resp_ready = 1'b0;
      return;
    end
    rdata = resp_rdata;
    err   = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("hold_valid", {31'b0, resp_valid}, 32'h1);
      checkOutput("hold_req_ready", {31'b0, req_ready}, 32'h0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    @(negedge clk);
    checkOutput("idle_req_ready", {31'b0, req_ready}, 32'h1);
    checkOutput("idle_resp_valid", {31'b0, resp_valid}, 32'h0);
  endtask

  task automatic setL1(input int i, input logic [31:0] data [4]);
    l1_req_valid = 1'b1;
    l1_req_we    = (i < 4);
    l1_req_addr  = BASE + 32'(4 * (i % 4)) + 32'($urandom_range(0, 3));
    l1_req_wdata = (i < 4) ? data[i] : $urandom;
    l1_req_mask  = 32'hFFFF_FFFF;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] addr;
    logic [31:0] l1_data [4];

    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'h0);
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_resp_err", {31'b0, resp_err}, 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, BASE + 32'(4 * i), 32'h1000_0000 + 32'(i),
                    32'hFFFF_FFFF, 0, 1'b0, rd, er, lat);
    end

    applyStimulus(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 1'b0, rd, er, lat);
    checkOutput("wr_latency", 32'(lat), 32'd2);
    checkOutput("wr_rdata", rd, 32'h0);
    applyStimulus(1'b0, 32'h8000_0010, 32'h0, 32'h0, 0, 1'b0, rd, er, lat);
    checkOutput("rd_latency", 32'(lat), 32'd2);
    checkOutput("rd_rdata", rd, 32'hDEAD_BEEF);
    checkOutput("rd_err", {31'b0, er}, 32'h0);

    applyStimulus(1'b1, 32'h8000_0010, 32'h1122_3344, 32'h0000_FF00, 0, 1'b0, rd, er, lat);
    applyStimulus(1'b0, 32'h8000_0010, 32'h0, 32'h0, 0, 1'b0, rd, er, lat);
    checkOutput("masked_rdata", rd, 32'hDEAD_33EF);

    applyStimulus(1'b0, 32'h7FFF_FFFC, 32'h0, 32'h0, 0, 1'b0, rd, er, lat);
    checkOutput("below_err", {31'b0, er}, 32'h1);
    checkOutput("below_rdata", rd, 32'h0);
    applyStimulus(1'b0, BASE + 32'(4 * DEPTH), 32'h0, 32'h0, 0, 1'b0, rd, er, lat);
    checkOutput("above_err", {31'b0, er}, 32'h1);
    checkOutput("above_rdata", rd, 32'h0);
    applyStimulus(1'b1, BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, rd, er, lat);
    checkOutput("oob_wr_err", {31'b0, er}, 32'h1);
    applyStimulus(1'b0, BASE, 32'h0, 32'h0, 0, 1'b0, rd, er, lat);
    checkOutput("word0_intact", rd, 32'h1000_0000);

    applyStimulus(1'b0, 32'h8000_0010, 32'h0, 32'h0, 5, 1'b1, rd, er, lat);
    checkOutput("held_rdata", rd, 32'hDEAD_33EF);

    // Reset while the write's response is still in flight.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8000_0014;
    req_wdata = 32'h5A5A_A5A5; req_mask = 32'hFFFF_FFFF; resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("rstbusy_accept", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #2;
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    #1;
    checkOutput("rstbusy_valid", {31'b0, resp_valid}, 32'h0);
    checkOutput("rstbusy_ready", {31'b0, req_ready}, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checkOutput("rst_no_resp", {31'b0, resp_valid}, 32'h0);
    end
    applyStimulus(1'b0, 32'h8000_0014, 32'h0, 32'h0, 0, 1'b0, rd, er, lat);
    checkOutput("rst_write_kept", rd, 32'h5A5A_A5A5);

    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 14))
        0:       addr = BASE - 32'(4 * $urandom_range(1, 4));
        1:       addr = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 64));
        2:       addr = 32'hFFFF_FFFC;
        default: addr = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      endcase
      applyStimulus(1'($urandom_range(0, 1)), addr, $urandom, $urandom,
                    $urandom_range(0, 3), 1'b1, rd, er, lat);
      checkOutput("rand_latency", 32'(lat), 32'(LAT));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // LATENCY=1 instance: back-to-back transactions, one every two cycles.
    for (int i = 0; i < 4; i++) l1_data[i] = $urandom;
    @(posedge clk); #1;
    setL1(0, l1_data);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("l1_accept_ready", {31'b0, l1_req_ready}, 32'h1);
      @(posedge clk); #1;
      if (i < 7) setL1(i + 1, l1_data);
      else l1_req_valid = 1'b0;
      @(negedge clk);
      checkOutput("l1_resp_valid", {31'b0, l1_resp_valid}, 32'h1);
      checkOutput("l1_resp_rdata", l1_resp_rdata, (i < 4) ? 32'h0 : l1_data[i - 4]);
      checkOutput("l1_resp_err", {31'b0, l1_resp_err}, 32'h0);
      checkOutput("l1_busy_ready", {31'b0, l1_req_ready}, 32'h0);
    end
    @(negedge clk);
    checkOutput("l1_done_valid", {31'b0, l1_resp_valid}, 32'h0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder (target side) for the MEM stage's data-memory request interface (dm_addr / dm_we / dm_re / dm_mask / dm_rdata).
- Accepts one request at a time over a valid/ready handshake.
- Writes are bit-masked and commit on the accept edge; responses come back after a fixed, parameterised latency.
- Sits between the core's MEM stage and on-chip data storage; it is the simulation and FPGA stand-in for a real data bus.

Parameters:
- WIDTH, 32, data/address width in bits (power of 2, ≥ 16).
- DEPTH, 1024, number of WIDTH-bit words of storage.
- BASE_ADDR, 32'h8000_0000, byte address of word 0; must be aligned to WIDTH/8.
- LATENCY, 2, cycles from the accept edge to resp_valid rising (≥ 1).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  WIDTH  byte address.
- req_wdata  in  WIDTH  write data.
- req_mask  in  WIDTH  per-bit write enable (1 = bit written); ignored on reads.
- resp_valid  out  1  response available.
- resp_ready  in  1  initiator consumes response.
- resp_rdata  out  WIDTH  read data (0 for writes and for errors).
- resp_err  out  1  address out of range.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, latency counter=0.
  - resp_valid=0, resp_rdata=0, resp_err=0; req_ready=0 while rst is high.
  - Storage contents are not reset.
- Reset mid-operation: an in-flight transaction is dropped with no response. A write already committed at its accept edge stays committed.
- States: IDLE, BUSY, RESP. Only one transaction is outstanding at a time.
- req_ready = (state==IDLE) && !rst. Accept = req_valid && req_ready at a rising edge.
- Address decode:
  - off = req_addr − BASE_ADDR.
  - idx = off >> log2(WIDTH/8). The low log2(WIDTH/8) address bits are ignored; the initiator aligns and uses the mask.
  - in_range = (req_addr ≥ BASE_ADDR) && (idx < DEPTH), computed without wrap-around.
- On the accept edge:
  - Latch we, idx and in_range.
  - If write and in_range: mem[idx] <= (mem[idx] & ~req_mask) | (req_wdata & req_mask).
  - If write and out of range: storage is untouched.
  - Next state: RESP if LATENCY==1; otherwise BUSY with counter loaded to LATENCY−2.
- BUSY:
  - Counter decrements each cycle.
  - When the counter is 0, the next edge moves to RESP.
  - The response registers load on that same edge: rdata = mem[idx] for an in-range read, else 0; err = !in_range.
- Latency: resp_valid is high exactly LATENCY cycles after the accept edge.
- RESP:
  - resp_valid=1, and resp_rdata/resp_err are held stable until the handshake.
  - When resp_ready=1, the next edge goes to IDLE and resp_valid falls.
  - resp_rdata and resp_err return to 0 on that edge.
  - resp_ready may be held high in advance; a response still lasts ≥ 1 cycle.
- Throughput: at best one transaction per LATENCY+1 cycles. req_ready is 0 in BUSY and RESP, so there is no overlap.
- Read-after-write to the same word returns the merged data, because the write commits at accept.
- req_* inputs are sampled only at accept and may change freely afterwards.
- Simultaneous rst and req_valid: reset wins; nothing is accepted or written.

Decomposition:
- Shared package/header holds:
  - the FSM state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2);
  - the default BASE_ADDR constant.
- One sub-module, dmem_array: DEPTH×WIDTH storage with a single synchronous masked-write port and a combinational read by index.
- The FSM, counter and decode stay in dmem_responder.

Test Plan:
- Reset, then write addr 8000_0010, data DEADBEEF, mask FFFFFFFF. Then read 8000_0010 → resp_valid exactly 2 cycles after each accept; rdata=DEADBEEF; err=0.
- Masked write of data 11223344 with mask 0000FF00 over DEADBEEF, then read → rdata=DEAD33EF.
- Read 7FFF_FFFC, and read BASE_ADDR+4×DEPTH → err=1, rdata=0. A write to an out-of-range address leaves word 0 unchanged (verify by reading it).
- Hold resp_ready=0 for 5 cycles in RESP → resp_valid/rdata stay stable and req_ready=0 throughout. Raise resp_ready → IDLE next cycle and req_ready=1.
- Assert rst asynchronously (mid-cycle) while in BUSY → resp_valid=0 immediately, with no response after release. A write accepted before the reset is visible to a subsequent read.
- LATENCY=1 build: back-to-back reads with resp_ready tied 1 → resp_valid 1 cycle after accept; one transaction every 2 cycles.
